// File: rtl/mem_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port fixed-latency memory
//           between the instruction fetch port and the load/store port.
// Latency : grant and mem_en in the request cycle T (combinational from IDLE),
//           rvalid at T+MEM_LATENCY, next grant no earlier than T+MEM_LATENCY+1.
// Backpr. : one access in flight; requests are held by the requester until
//           *_gnt, and are simply not granted while busy (no queueing, no drop).
//
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   if_req/if_addr -> if_gnt   fetch request, accept strobe
//   if_rvalid/if_rdata         fetch data pulse (rdata 0 when not valid)
//   ls_req/ls_we/ls_addr/ls_wdata -> ls_gnt   load/store request, accept strobe
//   ls_rvalid/ls_rdata         load data / store completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata   memory side
//   busy                       transaction in flight
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic       OWN_IF   = 1'b0;
    localparam logic       OWN_LS   = 1'b1;
    localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic       we_q, we_d;     // owner's access is a store

    logic       pick_ls;
    logic       grant;
    logic       done;

    // On contention the port that did not win last time goes first.
    always_comb begin
        if (if_req && ls_req) begin
            pick_ls = (last_grant_q == OWN_IF);
        end else begin
            pick_ls = ls_req;
        end
    end

    // rst_n gating keeps every output quiet while reset is held, even though
    // the grant path is combinational from the request inputs.
    assign grant = rst_n && (state_q == IDLE) && (if_req || ls_req);
    assign done  = rst_n && (state_q == WAIT) && (cnt_q == CNT_LAST);

    assign if_gnt    = grant && !pick_ls;
    assign ls_gnt    = grant && pick_ls;
    assign mem_en    = grant;
    assign mem_we    = ls_gnt && ls_we;
    assign mem_addr  = grant ? (pick_ls ? ls_addr : if_addr) : '0;
    assign mem_wdata = mem_we ? ls_wdata : '0;

    assign if_rvalid = done && (owner_q == OWN_IF);
    assign ls_rvalid = done && (owner_q == OWN_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    // A store completes with a pulse but carries no data.
    assign ls_rdata  = (ls_rvalid && !we_q) ? mem_rdata : '0;
    assign busy      = rst_n && (state_q == WAIT);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d      = WAIT;
                    cnt_d        = 4'd1;
                    owner_d      = pick_ls;
                    last_grant_d = pick_ls;
                    we_d         = pick_ls && ls_we;
                end
            end
            WAIT: begin
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_LS;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Three arbiter instances (MEM_LATENCY 1, 2, 3), each with its own memory model
// and its own request inputs; rst_n and clk are shared.
module tb_mem_arbiter;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        if_req    [NI];
    logic [7:0]  if_addr   [NI];
    logic        if_gnt    [NI];
    logic        if_rvalid [NI];
    logic [31:0] if_rdata  [NI];
    logic        ls_req    [NI];
    logic        ls_we     [NI];
    logic [7:0]  ls_addr   [NI];
    logic [31:0] ls_wdata  [NI];
    logic        ls_gnt    [NI];
    logic        ls_rvalid [NI];
    logic [31:0] ls_rdata  [NI];
    logic        mem_en    [NI];
    logic        mem_we    [NI];
    logic [7:0]  mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    logic        busy      [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [31:0] mem  [256];
        logic [31:0] pipe [3];

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
            mem[8'h10] = 32'hDEAD_BEEF;
            for (int i = 0; i < 3; i++) pipe[i] = 32'h0;
        end

        // Read data appears g+1 cycles after mem_en; non-read cycles return junk
        // so the DUT has to gate rdata itself.
        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
            pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 32'hBAD0_BAD0;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign mem_rdata[g] = pipe[g];

        mem_arbiter #(
            .ADDR_WIDTH (8),
            .DATA_WIDTH (32),
            .MEM_LATENCY(g + 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_gnt   (if_gnt[g]),
            .if_rvalid(if_rvalid[g]),
            .if_rdata (if_rdata[g]),
            .ls_req   (ls_req[g]),
            .ls_we    (ls_we[g]),
            .ls_addr  (ls_addr[g]),
            .ls_wdata (ls_wdata[g]),
            .ls_gnt   (ls_gnt[g]),
            .ls_rvalid(ls_rvalid[g]),
            .ls_rdata (ls_rdata[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );
    end

    typedef struct {
        logic        if_req;
        logic [7:0]  if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [7:0]  ls_addr;
        logic [31:0] ls_wdata;
        logic        e_if_gnt;
        logic        e_ls_gnt;
        logic        e_mem_en;
        logic        e_mem_we;
        logic [7:0]  e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic        e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_ls_rvalid;
        logic [31:0] e_ls_rdata;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic [7:0] ia, input logic lr, input logic lw,
        input logic [7:0] la, input logic [31:0] ld,
        input logic ig, input logic lg, input logic en, input logic we,
        input logic [7:0] ma, input logic [31:0] md,
        input logic iv, input logic [31:0] id, input logic lv,
        input logic [31:0] lrd, input logic b);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;  v.ls_req = lr;  v.ls_we = lw;
        v.ls_addr = la; v.ls_wdata = ld;
        v.e_if_gnt = ig; v.e_ls_gnt = lg; v.e_mem_en = en; v.e_mem_we = we;
        v.e_mem_addr = ma; v.e_mem_wdata = md;
        v.e_if_rvalid = iv; v.e_if_rdata = id;
        v.e_ls_rvalid = lv; v.e_ls_rdata = lrd; v.e_busy = b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic ir, input logic [7:0] ia,
                         input logic lr, input logic lw, input logic [7:0] la,
                         input logic [31:0] ld);
        if_req[k] = ir; if_addr[k] = ia;
        ls_req[k] = lr; ls_we[k] = lw; ls_addr[k] = la; ls_wdata[k] = ld;
    endtask

    task automatic chk_quiet(input int k, input string nm);
        chk({nm, " if_gnt"},    32'(if_gnt[k]),    32'h0);
        chk({nm, " ls_gnt"},    32'(ls_gnt[k]),    32'h0);
        chk({nm, " mem_en"},    32'(mem_en[k]),    32'h0);
        chk({nm, " mem_addr"},  32'(mem_addr[k]),  32'h0);
        chk({nm, " if_rvalid"}, 32'(if_rvalid[k]), 32'h0);
        chk({nm, " ls_rvalid"}, 32'(ls_rvalid[k]), 32'h0);
        chk({nm, " busy"},      32'(busy[k]),      32'h0);
    endtask

    vec_t tbl [23];

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) drive(k, 0, 8'h0, 0, 0, 8'h0, 32'h0);

        // ---------------- reset state: requests high, outputs must stay 0
        drive(0, 1, 8'h10, 1, 1, 8'h22, 32'hFFFF_FFFF);
        step(); step();
        @(negedge clk);
        chk_quiet(0, "reset");
        chk("reset mem_we",    32'(mem_we[0]),    32'h0);
        chk("reset mem_wdata", mem_wdata[0],      32'h0);
        step();
        drive(0, 0, 8'h0, 0, 0, 8'h0, 32'h0);
        rst_n = 1'b1;

        // ---------------- table: instance 0, MEM_LATENCY = 1
        //          if_req/addr   ls_req/we/addr/wdata         ifg lsg en we maddr mwdata          ifv ifdata           lsv lsdata           busy
        tbl[0]  = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 32'h0,           0, 32'h0,           0, 32'h0,           0);
        // both request right after reset: IF first, then alternate
        tbl[1]  = mk(1, 8'h01, 1, 0, 8'h02, 32'h1111_1111,   1, 0, 1, 0, 8'h01, 32'h0,           0, 32'h0,           0, 32'h0,           0);
        tbl[2]  = mk(1, 8'h01, 1, 0, 8'h02, 32'h1111_1111,   0, 0, 0, 0, 8'h00, 32'h0,           1, 32'hC0DE_0001,   0, 32'h0,           1);
        tbl[3]  = mk(1, 8'h01, 1, 0, 8'h02, 32'h1111_1111,   0, 1, 1, 0, 8'h02, 32'h0,           0, 32'h0,           0, 32'h0,           0);
        tbl[4]  = mk(1, 8'h01, 1, 0, 8'h02, 32'h1111_1111,   0, 0, 0, 0, 8'h00, 32'h0,           0, 32'h0,           1, 32'hC0DE_0002,   1);
        tbl[5]  = mk(1, 8'h01, 1, 0, 8'h02, 32'h1111_1111,   1, 0, 1, 0, 8'h01, 32'h0,           0, 32'h0,           0, 32'h0,           0);
        tbl[6]  = mk(1, 8'h01, 1, 0, 8'h02, 32'h1111_1111,   0, 0, 0, 0, 8'h00, 32'h0,           1, 32'hC0DE_0001,   0, 32'h0,           1);
        tbl[7]  = mk(1, 8'h01, 1, 0, 8'h02, 32'h1111_1111,   0, 1, 1, 0, 8'h02, 32'h0,           0, 32'h0,           0, 32'h0,           0);
        tbl[8]  = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 32'h0,           0, 32'h0,           1, 32'hC0DE_0002,   1);
        tbl[9]  = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 32'h0,           0, 32'h0,           0, 32'h0,           0);
        // lone fetch of 0x10
        tbl[10] = mk(1, 8'h10, 0, 0, 8'h00, 32'h0,           1, 0, 1, 0, 8'h10, 32'h0,           0, 32'h0,           0, 32'h0,           0);
        tbl[11] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 32'h0,           1, 32'hDEAD_BEEF,   0, 32'h0,           1);
        // store then load back
        tbl[12] = mk(0, 8'h00, 1, 1, 8'h30, 32'hCAFE_F00D,   0, 1, 1, 1, 8'h30, 32'hCAFE_F00D,   0, 32'h0,           0, 32'h0,           0);
        tbl[13] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 32'h0,           0, 32'h0,           1, 32'h0,           1);
        tbl[14] = mk(0, 8'h00, 1, 0, 8'h30, 32'h5555_5555,   0, 1, 1, 0, 8'h30, 32'h0,           0, 32'h0,           0, 32'h0,           0);
        tbl[15] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 32'h0,           0, 32'h0,           1, 32'hCAFE_F00D,   1);
        // lone LS wins even though LS had the last grant
        tbl[16] = mk(0, 8'h00, 1, 0, 8'h31, 32'h0,           0, 1, 1, 0, 8'h31, 32'h0,           0, 32'h0,           0, 32'h0,           0);
        tbl[17] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 32'h0,           0, 32'h0,           1, 32'hC0DE_0031,   1);
        // contention with last = LS: IF wins, LS waits and wins next IDLE
        tbl[18] = mk(1, 8'h05, 1, 0, 8'h06, 32'h0,           1, 0, 1, 0, 8'h05, 32'h0,           0, 32'h0,           0, 32'h0,           0);
        tbl[19] = mk(0, 8'h00, 1, 0, 8'h06, 32'h0,           0, 0, 0, 0, 8'h00, 32'h0,           1, 32'hC0DE_0005,   0, 32'h0,           1);
        tbl[20] = mk(0, 8'h00, 1, 0, 8'h06, 32'h0,           0, 1, 1, 0, 8'h06, 32'h0,           0, 32'h0,           0, 32'h0,           0);
        tbl[21] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 32'h0,           0, 32'h0,           1, 32'hC0DE_0006,   1);
        tbl[22] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0,           0, 0, 0, 0, 8'h00, 32'h0,           0, 32'h0,           0, 32'h0,           0);

        for (int i = 0; i < 23; i++) begin
            string r;
            step();
            drive(0, tbl[i].if_req, tbl[i].if_addr, tbl[i].ls_req, tbl[i].ls_we,
                  tbl[i].ls_addr, tbl[i].ls_wdata);
            @(negedge clk);
            r = $sformatf("row%0d", i);
            chk({r, " if_gnt"},    32'(if_gnt[0]),    32'(tbl[i].e_if_gnt));
            chk({r, " ls_gnt"},    32'(ls_gnt[0]),    32'(tbl[i].e_ls_gnt));
            chk({r, " mem_en"},    32'(mem_en[0]),    32'(tbl[i].e_mem_en));
            chk({r, " mem_we"},    32'(mem_we[0]),    32'(tbl[i].e_mem_we));
            chk({r, " mem_addr"},  32'(mem_addr[0]),  32'(tbl[i].e_mem_addr));
            chk({r, " mem_wdata"}, mem_wdata[0],      tbl[i].e_mem_wdata);
            chk({r, " if_rvalid"}, 32'(if_rvalid[0]), 32'(tbl[i].e_if_rvalid));
            chk({r, " if_rdata"},  if_rdata[0],       tbl[i].e_if_rdata);
            chk({r, " ls_rvalid"}, 32'(ls_rvalid[0]), 32'(tbl[i].e_ls_rvalid));
            chk({r, " ls_rdata"},  ls_rdata[0],       tbl[i].e_ls_rdata);
            chk({r, " busy"},      32'(busy[0]),      32'(tbl[i].e_busy));
        end

        // ---------------- store/load with MEM_LATENCY = 3 (instance 2)
        step();
        drive(2, 0, 8'h0, 1, 1, 8'h20, 32'h1234_5678);
        @(negedge clk);
        chk("st3 ls_gnt",    32'(ls_gnt[2]), 32'h1);
        chk("st3 mem_en",    32'(mem_en[2]), 32'h1);
        chk("st3 mem_we",    32'(mem_we[2]), 32'h1);
        chk("st3 mem_addr",  32'(mem_addr[2]), 32'h20);
        chk("st3 mem_wdata", mem_wdata[2],   32'h1234_5678);
        for (int c = 1; c <= 3; c++) begin
            step();
            drive(2, 0, 8'h0, 0, 0, 8'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("st3 c%0d ls_rvalid", c), 32'(ls_rvalid[2]), 32'(c == 3));
            chk($sformatf("st3 c%0d busy", c),      32'(busy[2]),      32'h1);
            chk($sformatf("st3 c%0d ls_rdata", c),  ls_rdata[2],       32'h0);
        end
        step();
        drive(2, 0, 8'h0, 1, 0, 8'h20, 32'h0);
        @(negedge clk);
        chk("ld3 ls_gnt", 32'(ls_gnt[2]), 32'h1);
        for (int c = 1; c <= 3; c++) begin
            step();
            drive(2, 0, 8'h0, 0, 0, 8'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("ld3 c%0d ls_rvalid", c), 32'(ls_rvalid[2]), 32'(c == 3));
            chk($sformatf("ld3 c%0d ls_rdata", c),  ls_rdata[2], (c == 3) ? 32'h1234_5678 : 32'h0);
        end

        // ---------------- LS request raised during an IF wait (instance 2)
        step();
        drive(2, 1, 8'h40, 0, 0, 8'h0, 32'h0);
        @(negedge clk);
        chk("late if_gnt", 32'(if_gnt[2]), 32'h1);
        for (int c = 1; c <= 4; c++) begin
            step();
            drive(2, 0, 8'h0, 1, 0, 8'h41, 32'h0);
            @(negedge clk);
            chk($sformatf("late c%0d ls_gnt", c),    32'(ls_gnt[2]),    32'(c == 4));
            chk($sformatf("late c%0d if_rvalid", c), 32'(if_rvalid[2]), 32'(c == 3));
        end
        chk("late mem_addr", 32'(mem_addr[2]), 32'h41);
        for (int c = 1; c <= 3; c++) begin
            step();
            drive(2, 0, 8'h0, 0, 0, 8'h0, 32'h0);
            @(negedge clk);
        end
        chk("late ls_rvalid", 32'(ls_rvalid[2]), 32'h1);
        chk("late ls_rdata",  ls_rdata[2],       32'hC0DE_0041);

        // ---------------- reset in the middle of a wait (instance 1, L=2)
        step();
        drive(1, 1, 8'h50, 0, 0, 8'h0, 32'h0);
        @(negedge clk);
        chk("rst if_gnt", 32'(if_gnt[1]), 32'h1);
        step();
        rst_n = 1'b0;
        drive(1, 1, 8'h50, 1, 0, 8'h51, 32'h0);
        @(negedge clk);
        chk_quiet(1, "midrst");
        step();
        drive(1, 0, 8'h0, 0, 0, 8'h0, 32'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("postrst c%0d if_rvalid", c), 32'(if_rvalid[1]), 32'h0);
            chk($sformatf("postrst c%0d busy", c),      32'(busy[1]),      32'h0);
            step();
        end
        drive(1, 1, 8'h52, 0, 0, 8'h0, 32'h0);
        @(negedge clk);
        chk("postrst if_gnt", 32'(if_gnt[1]), 32'h1);
        step();
        drive(1, 0, 8'h0, 0, 0, 8'h0, 32'h0);
        step();
        @(negedge clk);
        chk("postrst if_rvalid", 32'(if_rvalid[1]), 32'h1);
        chk("postrst if_rdata",  if_rdata[1],       32'hC0DE_0052);

        // ---------------- lone requester back-to-back, L=2 (instance 1)
        for (int c = 0; c <= 8; c++) begin
            step();
            drive(1, (c < 8), 8'h60, 0, 0, 8'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("b2b c%0d if_gnt", c),    32'(if_gnt[1]),    32'(c % 3 == 0));
            chk($sformatf("b2b c%0d if_rvalid", c), 32'(if_rvalid[1]), 32'(c % 3 == 2));
            chk($sformatf("b2b c%0d if_rdata", c),  if_rdata[1],
                (c % 3 == 2) ? 32'hC0DE_0060 : 32'h0);
            chk($sformatf("b2b c%0d ls_gnt", c),    32'(ls_gnt[1]),    32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
